// File: rtl/sm_rom_arbiter.sv
// Round-robin arbiter that shares one combinational instruction-ROM read port between fetch (F) and debug (D).
// Define SM_ROM_ARB_FETCH_PRIO_EN to give F fixed priority. D then only wins on cycles where F is idle.
module sm_rom_arbiter #(
   parameter int          SIZE     = 64,
   parameter logic [31:0] ERR_DATA = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_gnt,
   output logic        f_rvalid,
   output logic [31:0] f_rdata,
   output logic        f_err,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] rom_a,
   input  logic [31:0] rom_rd
);

   // state | meaning
   // PRI_F | F wins a tie (reset state; permanent under fixed priority)
   // PRI_D | D wins a tie
   typedef enum logic [0:0] {PRI_F = 1'b0, PRI_D = 1'b1} state_t;

   localparam logic [29:0] SIZE_W = 30'(SIZE);

   state_t      state, state_nxt;
   logic        prio_f;
   logic        bad_addr;
   logic [31:0] resp_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= PRI_F;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      prio_f    = (state == PRI_F);
      f_gnt     = 1'b0;
      d_gnt     = 1'b0;
      rom_a     = 32'h0;
      if (rst_n) begin
         f_gnt = f_req & (~d_req | prio_f);
         d_gnt = d_req & (~f_req | ~prio_f);
      end
      if (f_gnt)      rom_a = f_addr;
      else if (d_gnt) rom_a = d_addr;
`ifdef SM_ROM_ARB_FETCH_PRIO_EN
      state_nxt = PRI_F;
`else
      if (f_gnt)      state_nxt = PRI_D;
      else if (d_gnt) state_nxt = PRI_F;
`endif
   end

   // Full 30-bit word-index compare, so 4*SIZE and above never alias back onto low words.
   always_comb begin
      bad_addr  = (rom_a[1:0] != 2'b00) || (rom_a[31:2] >= SIZE_W);
      resp_data = bad_addr ? ERR_DATA : rom_rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_rvalid <= 1'b0;
         f_rdata  <= 32'h0;
         f_err    <= 1'b0;
         d_rvalid <= 1'b0;
         d_rdata  <= 32'h0;
         d_err    <= 1'b0;
      end else begin
         f_rvalid <= f_gnt;
         d_rvalid <= d_gnt;
         if (f_gnt) begin
            f_rdata <= resp_data;
            f_err   <= bad_addr;
         end
         if (d_gnt) begin
            d_rdata <= resp_data;
            d_err   <= bad_addr;
         end
      end
   end

endmodule
